// File: rtl/fpu_arbiter_pkg.sv
// fpu_arbiter_pkg: shared FPU op codes, arbiter state encoding and defaults
package fpu_arbiter_pkg;
   localparam logic [1:0] FPU_ADD  = 2'd0;
   localparam logic [1:0] FPU_SUB  = 2'd1;
   localparam logic [1:0] FPU_MUL  = 2'd2;
   localparam logic [1:0] FPU_SQRT = 2'd3;
   localparam int MAX_WAIT_DEF = 64;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: 2-way round-robin grant; a tie goes to the side not granted last
module fpu_rr_arbiter (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic accept,
   output logic gnt0,
   output logic gnt1
);
   logic last;
   assign gnt0 = req0 & (~req1 | last);
   assign gnt1 = req1 & (~req0 | ~last);
   // remember the winner only when a request is actually taken
   always_ff @(posedge clk or negedge reset)
      if (!reset) last <= 1'b1;
      else if (accept) last <= gnt1;
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one multi-cycle FPU between two requesters, with timeout
module fpu_arbiter
   import fpu_arbiter_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic             req1_valid,
   input  logic [1:0]       req0_op,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req0_ready,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_error,
   input  logic             rsp_ready,
   output logic [1:0]       fpu_operation,
   output logic [WIDTH-1:0] fpu_operand_1,
   output logic [WIDTH-1:0] fpu_operand_2,
   output logic             fpu_start,
   input  logic [WIDTH-1:0] fpu_result,
   input  logic             fpu_ready
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   state_t state, state_nx;
   logic gnt0, gnt1, accept, timeout, waiting;
   logic [CW-1:0] cnt;
   fpu_rr_arbiter u_rr (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0_valid),
      .req1   (req1_valid),
      .accept (accept),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );
   assign req0_ready = reset & (state == S_IDLE) & gnt0;
   assign req1_ready = reset & (state == S_IDLE) & gnt1;
   assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign waiting    = state == S_WAIT;
   assign timeout    = cnt == CW'(MAX_WAIT - 1);
   assign fpu_start  = state == S_ISSUE;
   assign rsp_valid  = state == S_RESP;
   // state register; reset drops any op in flight
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= S_IDLE;
      else state <= state_nx;
   // next state: one op in flight, ready wins over timeout in the last WAIT cycle
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = accept ? S_ISSUE : S_IDLE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  state_nx = (fpu_ready | timeout) ? S_RESP : S_WAIT;
         S_RESP:  state_nx = rsp_ready ? S_IDLE : S_RESP;
         default: state_nx = S_IDLE;
      endcase
   end
   // latch request on accept, count WAIT cycles, capture result or timeout
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         fpu_operation <= '0;
         fpu_operand_1 <= '0;
         fpu_operand_2 <= '0;
         rsp_id        <= 1'b0;
         rsp_result    <= '0;
         rsp_error     <= 1'b0;
         cnt           <= '0;
      end else begin
         if (accept) begin
            fpu_operation <= gnt1 ? req1_op : req0_op;
            fpu_operand_1 <= gnt1 ? req1_a : req0_a;
            fpu_operand_2 <= gnt1 ? req1_b : req0_b;
            rsp_id        <= gnt1;
         end
         cnt <= waiting ? cnt + CW'(1) : '0;
         if (waiting && fpu_ready) begin
            rsp_result <= fpu_result;
            rsp_error  <= 1'b0;
         end else if (waiting && timeout) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
         end
      end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed self-checking bench for fpu_arbiter
module tb_fpu_arbiter;
   import fpu_arbiter_pkg::*;
   localparam int W = 32;
   logic clk = 1'b0, reset = 1'b0;
   logic req0_valid = 0, req1_valid = 0, rsp_ready = 0, fpu_ready = 0;
   logic [1:0] req0_op = 0, req1_op = 0;
   logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, fpu_result = 0;
   logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_error, fpu_start;
   logic [W-1:0] rsp_result, fpu_operand_1, fpu_operand_2;
   logic [1:0] fpu_operation;
   int tests = 0, fails = 0, starts = 0, s0, n;
   logic ids [4];

   fpu_arbiter #(.WIDTH(W), .MAX_WAIT(64)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_error(rsp_error), .rsp_ready(rsp_ready),
      .fpu_operation(fpu_operation), .fpu_operand_1(fpu_operand_1),
      .fpu_operand_2(fpu_operand_2), .fpu_start(fpu_start),
      .fpu_result(fpu_result), .fpu_ready(fpu_ready)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (fpu_start) starts++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_rdy0"}, req0_ready, 0);
      check({tag, "_rdy1"}, req1_ready, 0);
      check({tag, "_vld"}, rsp_valid, 0);
      check({tag, "_id"}, rsp_id, 0);
      check({tag, "_res"}, rsp_result, 0);
      check({tag, "_err"}, rsp_error, 0);
      check({tag, "_start"}, fpu_start, 0);
      check({tag, "_op"}, fpu_operation, 0);
      check({tag, "_opa"}, fpu_operand_1, 0);
      check({tag, "_opb"}, fpu_operand_2, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      req0_valid = 1; req0_op = FPU_ADD; req0_a = 32'h600; req0_b = 32'h900; #1;
      chk_reset("rst");
      // release reset; first cycle after release accepts req0 ADD
      @(negedge clk); reset = 1; fpu_ready = 1; fpu_result = 32'hF00; #1;
      check("add_rdy0", req0_ready, 1);
      check("add_rdy1", req1_ready, 0);
      @(negedge clk); req0_valid = 0; #1;
      check("add_start", fpu_start, 1);
      check("add_op", fpu_operation, FPU_ADD);
      check("add_opa", fpu_operand_1, 32'h600);
      check("add_opb", fpu_operand_2, 32'h900);
      check("add_iss_rdy", req0_ready, 0);
      check("add_iss_vld", rsp_valid, 0);
      @(negedge clk);
      check("add_wait_start", fpu_start, 0);
      check("add_wait_vld", rsp_valid, 0);
      @(negedge clk);
      check("add_vld", rsp_valid, 1);
      check("add_res", rsp_result, 32'hF00);
      check("add_id", rsp_id, 0);
      check("add_err", rsp_error, 0);
      rsp_ready = 1;
      @(negedge clk);
      check("add_done", rsp_valid, 0);
      rsp_ready = 0; fpu_ready = 0;
      // req1 MUL with stale fpu_ready in ISSUE, real ready in 6th WAIT cycle
      req1_valid = 1; req1_op = FPU_MUL; req1_a = 32'h3; req1_b = 32'h5; #1;
      check("mul_rdy1", req1_ready, 1);
      check("mul_rdy0", req0_ready, 0);
      s0 = starts;
      @(negedge clk); req1_valid = 0; fpu_ready = 1; fpu_result = 32'hDEAD; #1;
      check("mul_start", fpu_start, 1);
      check("mul_op", fpu_operation, FPU_MUL);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check("mul_wait_vld", rsp_valid, 0);
         fpu_ready = (i == 6);
         fpu_result = (i == 6) ? 32'h12345678 : 32'hBAD;
      end
      @(negedge clk); fpu_ready = 0; #1;
      check("mul_starts", starts - s0, 1);
      check("mul_vld", rsp_valid, 1);
      check("mul_id", rsp_id, 1);
      check("mul_res", rsp_result, 32'h12345678);
      check("mul_err", rsp_error, 0);
      // hold RESP for 10 cycles with a new request pending
      req0_valid = 1; req0_op = FPU_SUB; req0_a = 32'h7; req0_b = 32'h8; #1;
      for (int i = 0; i < 10; i++) begin
         check("stall_vld", rsp_valid, 1);
         check("stall_id", rsp_id, 1);
         check("stall_res", rsp_result, 32'h12345678);
         check("stall_err", rsp_error, 0);
         check("stall_rdy0", req0_ready, 0);
         check("stall_rdy1", req1_ready, 0);
         @(negedge clk); #1;
      end
      rsp_ready = 1;
      @(negedge clk); rsp_ready = 0; #1;
      check("stall_idle_vld", rsp_valid, 0);
      check("stall_idle_rdy0", req0_ready, 1);
      // timeout: fpu_ready never asserted
      @(negedge clk); req0_valid = 0; #1;
      check("to_op", fpu_operation, FPU_SUB);
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (i == 64) check("to_wait64_vld", rsp_valid, 0);
      end
      @(negedge clk);
      check("to_vld", rsp_valid, 1);
      check("to_err", rsp_error, 1);
      check("to_res", rsp_result, 0);
      check("to_id", rsp_id, 0);
      rsp_ready = 1;
      @(negedge clk); rsp_ready = 0; req0_valid = 1; #1;
      check("edge_rdy0", req0_ready, 1);
      // fpu_ready in the 64th WAIT cycle wins over the timeout
      @(negedge clk); req0_valid = 0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (i == 64) begin fpu_ready = 1; fpu_result = 32'hABC; end
      end
      @(negedge clk); fpu_ready = 0;
      check("edge_vld", rsp_valid, 1);
      check("edge_err", rsp_error, 0);
      check("edge_res", rsp_result, 32'hABC);
      rsp_ready = 1;
      @(negedge clk); rsp_ready = 0;
      // reset while an op waits on the FPU
      req1_valid = 1; req1_op = FPU_SQRT; req1_a = 32'h55; req1_b = 32'h66;
      @(negedge clk); req1_valid = 0; #1;
      check("sq_opa", fpu_operand_1, 32'h55);
      check("sq_id_pre", req1_ready, 0);
      repeat (2) @(negedge clk);
      reset = 0;
      req0_valid = 1; req0_op = FPU_SUB; req0_a = 32'h900; req0_b = 32'h600; req1_valid = 1; #1;
      chk_reset("wrst");
      @(negedge clk);
      check("wrst_vld", rsp_valid, 0);
      reset = 1; #1;
      check("sub_rdy0", req0_ready, 1);
      check("sub_rdy1", req1_ready, 0);
      @(negedge clk); req0_valid = 0; req1_valid = 0; fpu_ready = 1; fpu_result = 32'h300; #1;
      check("sub_op", fpu_operation, FPU_SUB);
      check("sub_opa", fpu_operand_1, 32'h900);
      check("sub_opb", fpu_operand_2, 32'h600);
      repeat (2) @(negedge clk);
      check("sub_vld", rsp_valid, 1);
      check("sub_res", rsp_result, 32'h300);
      check("sub_id", rsp_id, 0);
      check("sub_err", rsp_error, 0);
      // both requesters continuously valid from reset: alternate 0,1,0,1
      fpu_ready = 0; reset = 0;
      @(negedge clk);
      reset = 1; req0_valid = 1; req1_valid = 1; rsp_ready = 1; fpu_ready = 1; fpu_result = 32'h777;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         if (rsp_valid) begin ids[n] = rsp_id; n++; end
      end
      check("rr_count", n, 4);
      for (int i = 0; i < 4; i++) check("rr_id", (i < n) ? ids[i] : 1'bx, i % 2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
